ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port synchronous RAM between three requesters: instruction fetch (if), load/store data access (dm), and the debug/program loader (dbg).
- Replaces the fixed fetch/data address mux in front of the RAM macro with a req/gnt arbiter.
- Provides aging-based starvation protection and read-data return tracking over a fixed RAM read latency.

Parameters:
- ADDR_W, 30, word address width (byte address [31:2]).
- DATA_W, 32, data width.
- RD_LAT, 1, cycles from read grant to valid ram_q; legal values 1 or 2.
- STARVE_MAX, 4, consecutive denied cycles after which if/dbg is promoted.
- LOCK_MAX, 8, maximum consecutive dm grants while locked (only with RAM_ARB_LOCK_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; if_addr  in  ADDR_W  fetch address; if_gnt  out  1; if_rvalid  out  1.
- dm_req  in  1; dm_we  in  1; dm_addr  in  ADDR_W; dm_wdata  in  DATA_W; dm_lock  in  1; dm_gnt  out  1; dm_rvalid  out  1.
- dbg_req  in  1; dbg_we  in  1; dbg_addr  in  ADDR_W; dbg_wdata  in  DATA_W; dbg_gnt  out  1; dbg_rvalid  out  1.
- rdata  out  DATA_W  shared read data, qualified by the *_rvalid strobes.
- ram_address  out  ADDR_W; ram_data  out  DATA_W; ram_wren  out  1; ram_q  in  DATA_W  RAM macro interface.

Behaviour:
- Handshake: a requester holds req, addr, we and wdata stable until gnt=1. The transfer occurs in the cycle where req&gnt. Grants are combinational from the current req and registered state. At most one gnt is high per cycle.
- Priority, highest first:
  - starved if (age counter == STARVE_MAX)
  - starved dbg
  - dm
  - dbg
  - if
- Age counters (if, dbg):
  - increment when req&!gnt
  - clear on gnt or !req
  - saturate at STARVE_MAX
- RAM drive:
  - ram_address, ram_data and ram_wren = winner's addr, wdata and we.
  - No winner: ram_address=0, ram_data=0, ram_wren=0.
- Read return:
  - A granted read (we=0) pushes its port ID into an RD_LAT-deep ID shift register.
  - After RD_LAT cycles, exactly one *_rvalid pulses for 1 cycle and rdata=ram_q.
  - Writes produce no rvalid.
- Back-to-back reads from any mix of ports: one grant per cycle. Returns arrive in grant order, one per cycle.
- Reset (asynchronous, any time):
  - age counters=0, ID pipe=NONE, lock FSM=UNLOCKED.
  - All gnt, rvalid and ram_wren are 0 while reset=1.
  - In-flight reads are dropped: no rvalid after reset release.
- Simultaneous if and dbg starved: if wins. dbg's counter stays saturated, so dbg wins the next cycle unless if is starved again. if cannot re-starve within 1 cycle because its counter clears on grant.

Optional Feature:
- Macro RAM_ARB_LOCK_EN.
- With the macro: lock FSM with states UNLOCKED and LOCKED, plus a lock counter lock_cnt.
  - UNLOCKED→LOCKED when dm is granted with dm_lock=1; lock_cnt=1.
  - In LOCKED, only dm may be granted; starvation promotion is suppressed, but age counters still count.
  - Each dm grant increments lock_cnt.
  - LOCKED→UNLOCKED when dm_lock=0, or when lock_cnt==LOCK_MAX. On the LOCK_MAX exit, dm is excluded for one cycle (forced release).
- Without the macro: dm_lock is ignored, the FSM and lock_cnt are absent, and dm_lock is unconnected internally.

Decomposition:
- Package kanade32_ram_pkg holds:
  - port ID enum: PORT_NONE, PORT_IF, PORT_DM, PORT_DBG
  - lock state enum: LOCK_UNLOCKED, LOCK_LOCKED
  - default widths
- One sub-module, ram_arb_age_counter (saturating req-age counter with a starved flag), instantiated for if and dbg.

Test Plan:
- if_req=1 alone, if_addr=0x10 → if_gnt=1 same cycle, ram_address=0x10; RD_LAT=1: if_rvalid=1 next cycle with rdata=ram_q.
- dm_req=1 (we=1, addr=0x20, wdata=0xDEADBEEF) with if_req=1 → dm_gnt=1, ram_wren=1, ram_data=0xDEADBEEF; if_gnt=0; no rvalid follows.
- dm_req held high for 6 cycles with if_req=1, STARVE_MAX=4 → if denied 4 cycles, then if_gnt=1 on cycle 5; dm resumes cycle 6.
- Reads dm@0x1, dbg@0x2, if@0x3 on consecutive cycles with RD_LAT=2 → dm_rvalid, dbg_rvalid, if_rvalid on consecutive cycles, 2 cycles after each grant, rdata matching each.
- reset asserted one cycle after a read grant → all gnt/rvalid drop to 0 immediately; no rvalid after reset release; counters 0.
- RAM_ARB_LOCK_EN, LOCK_MAX=8, dm_req=dm_lock=1 continuously with if_req=1 → 8 dm grants, then 1 cycle if_gnt=1, then dm re-locks.

Source files
------------

// File: rtl/kanade32_ram_pkg.sv
//------------------------------------------------------------------------------
// Package  : kanade32_ram_pkg
// Purpose  : Port IDs, lock states and default widths for the RAM arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package kanade32_ram_pkg;

    localparam int c_addr_w_default = 30;
    localparam int c_data_w_default = 32;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_IF   = 2'd1,
        PORT_DM   = 2'd2,
        PORT_DBG  = 2'd3
    } port_id_e;

    typedef enum logic [0:0] {
        LOCK_UNLOCKED = 1'b0,
        LOCK_LOCKED   = 1'b1
    } lock_state_e;

endpackage : kanade32_ram_pkg

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
//------------------------------------------------------------------------------
// Interface: ram_arbiter_if
// Purpose  : Requester req/gnt buses, shared read return and RAM macro pins.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface ram_arbiter_if
    import kanade32_ram_pkg::*;
#(
    parameter int ADDR_W = c_addr_w_default,
    parameter int DATA_W = c_data_w_default
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_lock;
    logic              dm_gnt;
    logic              dm_rvalid;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;

    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    // Requesters plus the RAM macro: drive requests and ram_q.
    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_lock,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output ram_q,
        input  if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid,
        input  rdata, ram_address, ram_data, ram_wren
    );

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_lock,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  ram_q,
        output if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid,
        output rdata, ram_address, ram_data, ram_wren
    );

endinterface : ram_arbiter_if

`default_nettype wire

// File: rtl/ram_arb_age_counter.sv
//------------------------------------------------------------------------------
// Module   : ram_arb_age_counter
// Purpose  : Saturating count of consecutive denied request cycles.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_arb_age_counter #(
    parameter int STARVE_MAX = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_req,
    input  wire logic i_gnt,
    output logic      o_starved
);

    localparam int                 c_age_w   = $clog2(STARVE_MAX + 1);
    localparam logic [c_age_w-1:0] c_age_max = c_age_w'(STARVE_MAX);

    logic [c_age_w-1:0] r_age;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_age <= '0;
        end else if (!i_req || i_gnt) begin
            r_age <= '0;
        end else if (r_age != c_age_max) begin
            r_age <= r_age + 1'b1;
        end
    end

    assign o_starved = (r_age == c_age_max);

endmodule : ram_arb_age_counter

`default_nettype wire

// File: rtl/ram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : ram_arbiter
// Purpose  : if/dm/dbg req-gnt arbiter for the single-port RAM with aging and
//            read-return tracking. RAM_ARB_LOCK_EN adds the dm bus-lock FSM.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
    import kanade32_ram_pkg::*;
#(
    parameter int ADDR_W     = c_addr_w_default,
    parameter int DATA_W     = c_data_w_default,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4,
    parameter int LOCK_MAX   = 8
) (
    input  wire logic    clk,
    input  wire logic    reset,
    ram_arbiter_if.slave bus
);

    generate
        if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
            $error("ram_arbiter: RD_LAT must be 1 or 2");
        end
        if (STARVE_MAX < 1 || LOCK_MAX < 1) begin : g_bad_limits
            $error("ram_arbiter: STARVE_MAX and LOCK_MAX must be at least 1");
        end
    endgenerate

    port_id_e          w_winner;
    port_id_e          w_rd_id;
    port_id_e          r_id_pipe [RD_LAT];
    logic              w_if_gnt;
    logic              w_dm_gnt;
    logic              w_dbg_gnt;
    logic              w_if_starved;
    logic              w_dbg_starved;
    logic              w_dm_allowed;
    logic              w_others_allowed;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_data;
    logic              w_ram_we;

`ifdef RAM_ARB_LOCK_EN
    localparam int                      c_lock_cnt_w = $clog2(LOCK_MAX + 1);
    localparam logic [c_lock_cnt_w-1:0] c_lock_one   = c_lock_cnt_w'(1);
    localparam logic [c_lock_cnt_w-1:0] c_lock_last  = c_lock_cnt_w'(LOCK_MAX - 1);

    lock_state_e             r_lock_state;
    logic [c_lock_cnt_w-1:0] r_lock_cnt;
    logic                    r_dm_block;

    // r_dm_block is the one-cycle forced release after a LOCK_MAX burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock_state <= LOCK_UNLOCKED;
            r_lock_cnt   <= '0;
            r_dm_block   <= 1'b0;
        end else begin
            r_dm_block <= 1'b0;
            case (r_lock_state)
                LOCK_UNLOCKED: begin
                    if (w_dm_gnt && bus.dm_lock) begin
                        r_lock_cnt <= c_lock_one;
                        if (LOCK_MAX <= 1) begin
                            r_dm_block <= 1'b1;
                        end else begin
                            r_lock_state <= LOCK_LOCKED;
                        end
                    end
                end
                LOCK_LOCKED: begin
                    if (!bus.dm_lock) begin
                        r_lock_state <= LOCK_UNLOCKED;
                        r_lock_cnt   <= '0;
                    end else if (w_dm_gnt) begin
                        if (r_lock_cnt >= c_lock_last) begin
                            r_lock_state <= LOCK_UNLOCKED;
                            r_lock_cnt   <= '0;
                            r_dm_block   <= 1'b1;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_lock_state <= LOCK_UNLOCKED;
                    r_lock_cnt   <= '0;
                end
            endcase
        end
    end

    assign w_dm_allowed     = !r_dm_block;
    assign w_others_allowed = (r_lock_state == LOCK_UNLOCKED);
`else
    assign w_dm_allowed     = 1'b1;
    assign w_others_allowed = 1'b1;
`endif

    ram_arb_age_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_if_age (
        .clk       (clk),
        .rst       (reset),
        .i_req     (bus.if_req),
        .i_gnt     (w_if_gnt),
        .o_starved (w_if_starved)
    );

    ram_arb_age_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_dbg_age (
        .clk       (clk),
        .rst       (reset),
        .i_req     (bus.dbg_req),
        .i_gnt     (w_dbg_gnt),
        .o_starved (w_dbg_starved)
    );

    // Starved requesters outrank dm; if wins a tie since its age clears on grant.
    always_comb begin
        w_winner = PORT_NONE;
        if (reset) begin
            w_winner = PORT_NONE;
        end else if (w_others_allowed && bus.if_req && w_if_starved) begin
            w_winner = PORT_IF;
        end else if (w_others_allowed && bus.dbg_req && w_dbg_starved) begin
            w_winner = PORT_DBG;
        end else if (w_dm_allowed && bus.dm_req) begin
            w_winner = PORT_DM;
        end else if (w_others_allowed && bus.dbg_req) begin
            w_winner = PORT_DBG;
        end else if (w_others_allowed && bus.if_req) begin
            w_winner = PORT_IF;
        end
    end

    assign w_if_gnt  = (w_winner == PORT_IF);
    assign w_dm_gnt  = (w_winner == PORT_DM);
    assign w_dbg_gnt = (w_winner == PORT_DBG);

    always_comb begin
        w_ram_addr = '0;
        w_ram_data = '0;
        w_ram_we   = 1'b0;
        case (w_winner)
            PORT_IF: begin
                w_ram_addr = bus.if_addr;
            end
            PORT_DM: begin
                w_ram_addr = bus.dm_addr;
                w_ram_data = bus.dm_wdata;
                w_ram_we   = bus.dm_we;
            end
            PORT_DBG: begin
                w_ram_addr = bus.dbg_addr;
                w_ram_data = bus.dbg_wdata;
                w_ram_we   = bus.dbg_we;
            end
            default: ;
        endcase
    end

    assign w_rd_id = (w_winner != PORT_NONE && !w_ram_we) ? w_winner : PORT_NONE;

    // Port ID travels alongside the RAM read so ram_q is steered to its owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_id_pipe[i] <= PORT_NONE;
            end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_id_pipe[i] <= r_id_pipe[i-1];
            end
            r_id_pipe[0] <= w_rd_id;
        end
    end

    assign bus.if_gnt      = w_if_gnt;
    assign bus.dm_gnt      = w_dm_gnt;
    assign bus.dbg_gnt     = w_dbg_gnt;
    assign bus.if_rvalid   = (r_id_pipe[RD_LAT-1] == PORT_IF);
    assign bus.dm_rvalid   = (r_id_pipe[RD_LAT-1] == PORT_DM);
    assign bus.dbg_rvalid  = (r_id_pipe[RD_LAT-1] == PORT_DBG);
    assign bus.rdata       = bus.ram_q;
    assign bus.ram_address = w_ram_addr;
    assign bus.ram_data    = w_ram_data;
    assign bus.ram_wren    = w_ram_we;

endmodule : ram_arbiter

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_ram_arbiter
// Purpose  : Directed bench; dut1 uses RD_LAT=1, dut2 RD_LAT=2, same stimulus.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(30), .DATA_W(32)) bus1 ();
    ram_arbiter_if #(.ADDR_W(30), .DATA_W(32)) bus2 ();

    ram_arbiter #(.RD_LAT(1), .STARVE_MAX(4), .LOCK_MAX(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    ram_arbiter #(.RD_LAT(2), .STARVE_MAX(4), .LOCK_MAX(8)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    assign bus2.if_req    = bus1.if_req;
    assign bus2.if_addr   = bus1.if_addr;
    assign bus2.dm_req    = bus1.dm_req;
    assign bus2.dm_we     = bus1.dm_we;
    assign bus2.dm_addr   = bus1.dm_addr;
    assign bus2.dm_wdata  = bus1.dm_wdata;
    assign bus2.dm_lock   = bus1.dm_lock;
    assign bus2.dbg_req   = bus1.dbg_req;
    assign bus2.dbg_we    = bus1.dbg_we;
    assign bus2.dbg_addr  = bus1.dbg_addr;
    assign bus2.dbg_wdata = bus1.dbg_wdata;

    // Read-only RAM model: word at address a reads as 0xA0000000 | a.
    logic [31:0] r_q2_stage;
    always @(posedge clk) begin
        bus1.ram_q <= 32'hA000_0000 | {2'b00, bus1.ram_address};
        r_q2_stage <= 32'hA000_0000 | {2'b00, bus2.ram_address};
        bus2.ram_q <= r_q2_stage;
    end

    logic [2:0] g1, rv1, rv2;
    assign g1  = {bus1.if_gnt, bus1.dm_gnt, bus1.dbg_gnt};
    assign rv1 = {bus1.if_rvalid, bus1.dm_rvalid, bus1.dbg_rvalid};
    assign rv2 = {bus2.if_rvalid, bus2.dm_rvalid, bus2.dbg_rvalid};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus1.if_req    = 1'b0;
        bus1.if_addr   = '0;
        bus1.dm_req    = 1'b0;
        bus1.dm_we     = 1'b0;
        bus1.dm_addr   = '0;
        bus1.dm_wdata  = '0;
        bus1.dm_lock   = 1'b0;
        bus1.dbg_req   = 1'b0;
        bus1.dbg_we    = 1'b0;
        bus1.dbg_addr  = '0;
        bus1.dbg_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] starve_if_seq;
    logic [5:0] starve_dm_seq;
    logic [2:0] tie_seq  [7];
    logic [2:0] lock_seq [10];

    initial begin
        starve_if_seq = 6'b010000;
        starve_dm_seq = 6'b101111;
        tie_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010};
`ifdef RAM_ARB_LOCK_EN
        lock_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
                     3'b010, 3'b010, 3'b010, 3'b100, 3'b010};
`else
        lock_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100,
                     3'b010, 3'b010, 3'b010, 3'b010, 3'b100};
`endif

        // Reset: requests present but nothing granted or returned.
        reset = 1'b1;
        clear_inputs();
        bus1.if_req  = 1'b1;
        bus1.if_addr = 30'h10;
        #2;
        chk("rst_gnt", g1, 3'b000);
        chk("rst_wren", bus1.ram_wren, 1'b0);
        chk("rst_rvalid", {rv1, rv2}, 6'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Lone fetch read.
        bus1.if_req  = 1'b1;
        bus1.if_addr = 30'h10;
        #1;
        chk("fetch_gnt", g1, 3'b100);
        chk("fetch_addr", bus1.ram_address, 30'h10);
        chk("fetch_wren", bus1.ram_wren, 1'b0);
        tick();
        clear_inputs();
        #1;
        chk("fetch_rv_lat1", rv1, 3'b100);
        chk("fetch_rdata_lat1", bus1.rdata, 32'hA000_0010);
        chk("fetch_rv_lat2_early", rv2, 3'b000);
        tick();
        chk("fetch_rv_lat2", rv2, 3'b100);
        chk("fetch_rdata_lat2", bus2.rdata, 32'hA000_0010);
        chk("fetch_rv_lat1_done", rv1, 3'b000);

        // dm write beats a pending fetch; write returns nothing.
        bus1.dm_req   = 1'b1;
        bus1.dm_we    = 1'b1;
        bus1.dm_addr  = 30'h20;
        bus1.dm_wdata = 32'hDEAD_BEEF;
        bus1.if_req   = 1'b1;
        bus1.if_addr  = 30'h11;
        #1;
        chk("wr_gnt", g1, 3'b010);
        chk("wr_wren", bus1.ram_wren, 1'b1);
        chk("wr_data", bus1.ram_data, 32'hDEAD_BEEF);
        chk("wr_addr", bus1.ram_address, 30'h20);
        tick();
        bus1.dm_req = 1'b0;
        bus1.dm_we  = 1'b0;
        #1;
        chk("wr_then_fetch_gnt", g1, 3'b100);
        chk("wr_no_rv_lat1", rv1, 3'b000);
        tick();
        clear_inputs();
        #1;
        chk("wr_fetch_rv_lat1", rv1, 3'b100);
        chk("wr_fetch_rdata_lat1", bus1.rdata, 32'hA000_0011);
        chk("wr_no_rv_lat2", rv2, 3'b000);
        tick();
        chk("wr_fetch_rv_lat2", rv2, 3'b100);

        // Continuous dm reads starve fetch until promotion on cycle 5.
        bus1.dm_req  = 1'b1;
        bus1.dm_addr = 30'h30;
        bus1.if_req  = 1'b1;
        bus1.if_addr = 30'h12;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("starve_if_gnt_c%0d", k + 1), bus1.if_gnt, starve_if_seq[k]);
            chk($sformatf("starve_dm_gnt_c%0d", k + 1), bus1.dm_gnt, starve_dm_seq[k]);
            tick();
        end
        clear_inputs();
        repeat (3) tick();

        // Back-to-back reads from three ports return in grant order.
        bus1.dm_req  = 1'b1;
        bus1.dm_addr = 30'h1;
        #1;
        chk("b2b_dm_gnt", g1, 3'b010);
        tick();
        bus1.dm_req   = 1'b0;
        bus1.dbg_req  = 1'b1;
        bus1.dbg_addr = 30'h2;
        #1;
        chk("b2b_dbg_gnt", g1, 3'b001);
        chk("b2b_dm_rv_lat1", rv1, 3'b010);
        chk("b2b_dm_rdata_lat1", bus1.rdata, 32'hA000_0001);
        tick();
        bus1.dbg_req = 1'b0;
        bus1.if_req  = 1'b1;
        bus1.if_addr = 30'h3;
        #1;
        chk("b2b_if_gnt", g1, 3'b100);
        chk("b2b_dm_rv_lat2", rv2, 3'b010);
        chk("b2b_dm_rdata_lat2", bus2.rdata, 32'hA000_0001);
        chk("b2b_dbg_rv_lat1", rv1, 3'b001);
        tick();
        clear_inputs();
        #1;
        chk("b2b_dbg_rv_lat2", rv2, 3'b001);
        chk("b2b_dbg_rdata_lat2", bus2.rdata, 32'hA000_0002);
        chk("b2b_if_rv_lat1", rv1, 3'b100);
        tick();
        chk("b2b_if_rv_lat2", rv2, 3'b100);
        chk("b2b_if_rdata_lat2", bus2.rdata, 32'hA000_0003);
        tick();

        // if and dbg starve together: if first, then dbg, then dm again.
        bus1.dm_req   = 1'b1;
        bus1.dbg_req  = 1'b1;
        bus1.if_req   = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("tie_gnt_c%0d", k + 1), g1, tie_seq[k]);
            tick();
        end
        clear_inputs();
        repeat (3) tick();

        // dm holding dm_lock with fetch pending.
        bus1.dm_req  = 1'b1;
        bus1.dm_lock = 1'b1;
        bus1.if_req  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("lock_gnt_c%0d", k + 1), g1, lock_seq[k]);
            tick();
        end
        clear_inputs();
        repeat (3) tick();

        // Reset one cycle after a read grant drops the in-flight return.
        bus1.dbg_req  = 1'b1;
        bus1.dbg_addr = 30'h5;
        bus1.if_req   = 1'b1;
        bus1.if_addr  = 30'h6;
        #1;
        chk("rr_dbg_gnt", g1, 3'b001);
        tick();
        bus1.dbg_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("rr_gnt_in_reset", g1, 3'b000);
        chk("rr_rv1_in_reset", rv1, 3'b000);
        chk("rr_rv2_in_reset", rv2, 3'b000);
        chk("rr_wren_in_reset", bus1.ram_wren, 1'b0);
        chk("rr_if_age", dut1.u_if_age.r_age, 64'd0);
        chk("rr_dbg_age", dut2.u_dbg_age.r_age, 64'd0);
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        chk("rr_rv1_after", rv1, 3'b000);
        chk("rr_rv2_after", rv2, 3'b000);
        tick();
        chk("rr_rv2_after2", rv2, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_ram_arbiter

`default_nettype wire
